// File: rtl/mm_cmd_sequencer.sv
// Command/response initiator for the matrix-multiply channel: sends the size word,
// one command per block, gathers checksum replies and closes the run with a zero word.
module mm_cmd_sequencer #(
    parameter int W_D         = 32,
    parameter int RSP_LATENCY = 2,
    parameter int TIMEOUT     = 65535
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           start,
    input  logic [W_D-1:0] cfg_matrix_size,
    input  logic [W_D-1:0] cfg_comp_size,
    input  logic [W_D-1:0] cfg_num_blocks,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [W_D-1:0] total_sum,
    output logic [W_D-1:0] last_sum,
    output logic [W_D-1:0] block_count,
    output logic           load_req,
    output logic           load_page,
    input  logic           load_ack,
    output logic [W_D-1:0] tx_d,
    output logic           tx_enq,
    input  logic           tx_full,
    input  logic [W_D-1:0] rx_q,
    output logic           rx_deq,
    input  logic           rx_empty
);

    typedef enum logic [3:0] {
        S_IDLE, S_SEND_SIZE, S_LOAD_REQ, S_SEND_CMD, S_WAIT_RSP,
        S_RSP_LAT, S_RSP_CAP, S_SEND_TERM, S_FINISH
    } state_t;

    localparam int             LW       = (RSP_LATENCY > 1) ? $clog2(RSP_LATENCY) : 1;
    localparam logic [LW-1:0]  LAT_LAST = LW'(RSP_LATENCY - 1);
    localparam logic [31:0]    TO_LAST  = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    state_t         r_state;
    logic [W_D-1:0] r_ms;
    logic [W_D-1:0] r_cs;
    logic [W_D-1:0] r_nb;
    logic           r_busy;
    logic           r_done;
    logic           r_error;
    logic [W_D-1:0] r_total;
    logic [W_D-1:0] r_last;
    logic [W_D-1:0] r_count;
    logic           r_load_req;
    logic           r_page;
    logic [W_D-1:0] r_tx_d;
    logic           r_rx_deq;
    logic [31:0]    r_to;
    logic [LW-1:0]  r_lat;

    logic           w_sending;
    logic [W_D-1:0] w_cnt_inc;

    // tx_enq follows tx_full combinationally so a full queue is never written.
    assign w_sending = (r_state == S_SEND_SIZE) || (r_state == S_SEND_CMD) ||
                       (r_state == S_SEND_TERM);
    assign w_cnt_inc = r_count + W_D'(1);

    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign total_sum   = r_total;
    assign last_sum    = r_last;
    assign block_count = r_count;
    assign load_req    = r_load_req;
    assign load_page   = r_page;
    assign tx_d        = r_tx_d;
    assign tx_enq      = w_sending & ~tx_full;
    assign rx_deq      = r_rx_deq;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_ms       <= '0;
            r_cs       <= '0;
            r_nb       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_total    <= '0;
            r_last     <= '0;
            r_count    <= '0;
            r_load_req <= 1'b0;
            r_page     <= 1'b0;
            r_tx_d     <= '0;
            r_rx_deq   <= 1'b0;
            r_to       <= '0;
            r_lat      <= '0;
        end else begin
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_rx_deq <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ms <= cfg_matrix_size;
                        r_cs <= cfg_comp_size;
                        r_nb <= cfg_num_blocks;
                        // A zero command word would read as a terminator on the core side.
                        if (cfg_matrix_size == '0 ||
                            (cfg_comp_size == '0 && cfg_num_blocks != '0)) begin
                            r_error <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                            r_total <= '0;
                            r_last  <= '0;
                            r_count <= '0;
                            r_page  <= 1'b0;
                            r_tx_d  <= cfg_matrix_size;
                            r_state <= S_SEND_SIZE;
                        end
                    end
                end
                S_SEND_SIZE: begin
                    if (!tx_full) begin
                        if (r_nb == '0) begin
                            r_tx_d  <= '0;
                            r_state <= S_SEND_TERM;
                        end else begin
                            r_load_req <= 1'b1;
                            r_state    <= S_LOAD_REQ;
                        end
                    end
                end
                S_LOAD_REQ: begin
                    if (load_ack) begin
                        r_load_req <= 1'b0;
                        r_tx_d     <= r_cs;
                        r_state    <= S_SEND_CMD;
                    end
                end
                S_SEND_CMD: begin
                    if (!tx_full) begin
                        r_to    <= '0;
                        r_state <= S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    if (!rx_empty) begin
                        r_rx_deq <= 1'b1;
                        r_lat    <= '0;
                        r_state  <= S_RSP_LAT;
                    end else if (TIMEOUT != 0 && r_to == TO_LAST) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_to <= r_to + 32'd1;
                    end
                end
                S_RSP_LAT: begin
                    if (r_lat == LAT_LAST) r_state <= S_RSP_CAP;
                    else                   r_lat   <= r_lat + LW'(1);
                end
                S_RSP_CAP: begin
                    r_last  <= rx_q;
                    r_total <= r_total + rx_q;
                    r_count <= w_cnt_inc;
                    r_page  <= ~r_page;
                    if (w_cnt_inc == r_nb) begin
                        r_tx_d  <= '0;
                        r_state <= S_SEND_TERM;
                    end else begin
                        r_load_req <= 1'b1;
                        r_state    <= S_LOAD_REQ;
                    end
                end
                S_SEND_TERM: begin
                    if (!tx_full) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mm_cmd_sequencer.md
Name: mm_cmd_sequencer

Overview:
- Hardware initiator for the matrix-multiply command/response channel; sits on the opposite side of the CoRAM channel from the mm compute core.
- Sends the matrix size, then one computation-size command per block, and collects one checksum reply per block.
- Handshakes with a page loader before each block and finishes with a zero terminator; reports the accumulated checksum.

Parameters:
- W_D, 32, data width of channel words, config inputs and sums
- RSP_LATENCY, 2, cycles from rx_deq pulse to valid rx_q (fixed channel read latency)
- TIMEOUT, 65535, max cycles in WAIT_RSP with rx_empty=1 before error (0 disables the watchdog)

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; latches the cfg_* inputs; ignored while busy=1
- cfg_matrix_size  in  W_D  matrix dimension sent as the first word
- cfg_comp_size  in  W_D  products per block, sent as each command word
- cfg_num_blocks  in  W_D  number of commands to issue
- busy  out  1  high from accepted start until done/error
- done  out  1  one-cycle pulse on normal completion
- error  out  1  one-cycle pulse on bad configuration or timeout
- total_sum  out  W_D  sum of all checksum replies, mod 2^W_D
- last_sum  out  W_D  most recent checksum reply
- block_count  out  W_D  replies received in the current run
- load_req  out  1  level; requests the loader to fill load_page
- load_page  out  1  page to fill; equals the compute core's current page
- load_ack  in  1  one-cycle pulse; page filled
- tx_d  out  W_D  word to the compute core
- tx_enq  out  1  enqueue strobe
- tx_full  in  1  core-bound queue full
- rx_q  in  W_D  reply word
- rx_deq  out  1  dequeue strobe
- rx_empty  in  1  reply queue empty

Behaviour:
- Reset: every output is 0, state is IDLE, and the page register is 0. A reset during an active run aborts it immediately: no terminator is sent and no done or error pulse is produced.
- States are IDLE, SEND_SIZE, LOAD_REQ, SEND_CMD, WAIT_RSP, RSP_LAT, RSP_CAP, SEND_TERM and FINISH.
- IDLE:
  - On start, latch the cfg_* inputs.
  - If cfg_matrix_size==0, or cfg_comp_size==0 with cfg_num_blocks>0, pulse error the next cycle and stay in IDLE. A comp_size of 0 would be decoded by the core as a terminator.
  - Otherwise set busy, clear total_sum, last_sum, block_count and page, and go to SEND_SIZE.
- Enqueue rule, applies to every SEND_* state:
  - tx_d holds the word while tx_full=1.
  - When tx_full=0, tx_enq is 1 for exactly one cycle and the state advances.
  - Never assert tx_enq while tx_full=1.
- SEND_SIZE: enqueue matrix_size. Go to SEND_TERM if num_blocks==0, else to LOAD_REQ.
- LOAD_REQ: load_req=1 with load_page=page. On load_ack, drop load_req in the following cycle and go to SEND_CMD. A load_ack seen outside LOAD_REQ is ignored.
- SEND_CMD: enqueue comp_size, clear the timeout counter, go to WAIT_RSP.
- WAIT_RSP:
  - If rx_empty=0, pulse rx_deq for one cycle and go to RSP_LAT.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT (TIMEOUT≠0), pulse error, clear busy and return to IDLE.
- RSP_LAT / RSP_CAP:
  - rx_q is sampled exactly RSP_LATENCY cycles after the rx_deq pulse.
  - On capture: last_sum<=rx_q; total_sum<=total_sum+rx_q, wrapping mod 2^W_D; block_count+1; page toggles.
  - If block_count+1==num_blocks go to SEND_TERM, else to LOAD_REQ.
- SEND_TERM: enqueue 0, go to FINISH.
- FINISH: done=1 for one cycle, busy=0, go to IDLE. total_sum, last_sum and block_count hold until the next accepted start.
- Only one command is outstanding at a time. A reply arriving early is simply dequeued when WAIT_RSP is entered.
- The rx_deq pulse is at most one per reply; no speculative dequeue.

Test Plan:
- Basic run: matrix_size=4, comp_size=16, num_blocks=3, replies 0x10, 0x20, 0x30 each returned 5 cycles after its command.
  - tx words are 4,16,16,16,0.
  - load_page sequence is 0,1,0.
  - total_sum=0x60, last_sum=0x30, block_count=3, then one done pulse.
- Backpressure: hold tx_full=1 for 7 cycles during SEND_CMD -> tx_d stable at 16 and tx_enq=0 throughout; exactly one enq after release.
- Zero blocks: num_blocks=0, matrix_size=8 -> tx words 8,0; no load_req; done pulses with total_sum=0.
- Bad config: comp_size=0, num_blocks=2 -> error pulses 1 cycle after start; no tx_enq; busy stays 0.
- Timeout: TIMEOUT=20, never return a reply -> error pulses 20 cycles after WAIT_RSP is entered; busy=0; no terminator sent. Then start again with a good config and the run completes normally.
- Wrap and reset: replies 0xFFFFFFFF and 0x2 -> total_sum=0x1. Then assert RST during LOAD_REQ of a new run -> all outputs are 0 the next cycle.
